// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control path: opcodes, ALU_Op
// codes (also decoded by ALUandALUControl), FSM states and the control word.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [1:0] ALUOP_ADD  = 2'b00;
  localparam logic [1:0] ALUOP_SUB  = 2'b01;
  localparam logic [1:0] ALUOP_FUNC = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_JUMP    = 4'd9,
    S_ADDIEX  = 4'd10,
    S_ADDIWB  = 4'd11
  } state_e;

  // Per-state control word; all-zero is the idle/recovery value.
  typedef struct packed {
    logic [1:0] alu_op;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic [1:0] pc_source;
    logic       pc_write;
    logic       pc_write_cond;
  } ctrl_t;

endpackage

// File: rtl/multicycle_control_outdec.sv
// Purely combinational state-to-control-word decoder (Moore outputs).
module multicycle_control_outdec
  import mips_ctrl_pkg::*;
(
  input  state_e state,
  output ctrl_t  ctrl
);

  // Decode the current state into datapath controls; unlisted fields stay 0.
  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.ir_write  = 1'b1;
        ctrl.alu_src_b = 2'b01;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.pc_write  = 1'b1;
      end
      S_DECODE: begin
        // PC + (imm << 2) lands in ALUOut as the speculative branch target.
        ctrl.alu_src_b = 2'b11;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEMADR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = 2'b10;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEMRD: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
      end
      S_MEMWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        ctrl.mem_write = 1'b1;
        ctrl.iord      = 1'b1;
      end
      S_EXECUTE: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_op    = ALUOP_FUNC;
      end
      S_ALUWB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_op        = ALUOP_SUB;
        ctrl.pc_source     = 2'b01;
        ctrl.pc_write_cond = 1'b1;
      end
      S_JUMP: begin
        ctrl.pc_source = 2'b10;
        ctrl.pc_write  = 1'b1;
      end
      S_ADDIEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = 2'b10;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_ADDIWB: begin
        ctrl.reg_write = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM of the multicycle MIPS datapath: state register,
// next-state logic and the Zero_Flag-qualified PC enable.
module multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         Opcode,
  input  logic               Zero_Flag,
  output logic [1:0]         ALU_Op,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic               IorD,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic               MemtoReg,
  output logic               RegDst,
  output logic               RegWrite,
  output logic [1:0]         PCSource,
  output logic               PC_En,
  output logic               Illegal_Op,
  output logic [STATE_W-1:0] State
);

  state_e state_q;
  state_e state_d;
  ctrl_t  ctrl;
  logic   illegal_d;

  // State register; reset forces FETCH so no partial writeback completes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // Next-state logic; Opcode only matters in DECODE and MEMADR (IR holds it).
  always_comb begin
    state_d   = S_FETCH;
    illegal_d = 1'b0;
    case (state_q)
      S_FETCH:   state_d = S_DECODE;
      S_DECODE: begin
        case (Opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXECUTE;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          OP_ADDI:      state_d = S_ADDIEX;
          default: begin
            state_d   = S_FETCH;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_MEMADR:  state_d = (Opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:   state_d = S_MEMWB;
      S_EXECUTE: state_d = S_ALUWB;
      S_ADDIEX:  state_d = S_ADDIWB;
      default:   state_d = S_FETCH;
    endcase
  end

  multicycle_control_outdec u_outdec (
    .state (state_q),
    .ctrl  (ctrl)
  );

  assign ALU_Op     = ctrl.alu_op;
  assign ALUSrcA    = ctrl.alu_src_a;
  assign ALUSrcB    = ctrl.alu_src_b;
  assign IorD       = ctrl.iord;
  assign MemRead    = ctrl.mem_read;
  assign MemWrite   = ctrl.mem_write;
  assign IRWrite    = ctrl.ir_write;
  assign MemtoReg   = ctrl.mem_to_reg;
  assign RegDst     = ctrl.reg_dst;
  assign RegWrite   = ctrl.reg_write;
  assign PCSource   = ctrl.pc_source;
  assign PC_En      = ctrl.pc_write | (ctrl.pc_write_cond & Zero_Flag);
  assign Illegal_Op = illegal_d;
  assign State      = STATE_W'(state_q);

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control; a tiny subtract model of the ALU
// supplies Zero_Flag from the A/B operand values.
module tb_multicycle_control;

  logic       clk;
  logic       reset;
  logic [5:0] Opcode;
  logic       Zero_Flag;
  logic [1:0] ALU_Op;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       IRWrite;
  logic       MemtoReg;
  logic       RegDst;
  logic       RegWrite;
  logic [1:0] PCSource;
  logic       PC_En;
  logic       Illegal_Op;
  logic [3:0] State;

  logic [31:0] a_val;
  logic [31:0] b_val;
  int n_checks;
  int n_fail;

  multicycle_control #(.STATE_W(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .Opcode     (Opcode),
    .Zero_Flag  (Zero_Flag),
    .ALU_Op     (ALU_Op),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .IorD       (IorD),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .IRWrite    (IRWrite),
    .MemtoReg   (MemtoReg),
    .RegDst     (RegDst),
    .RegWrite   (RegWrite),
    .PCSource   (PCSource),
    .PC_En      (PC_En),
    .Illegal_Op (Illegal_Op),
    .State      (State)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ALU zero flag as ALUandALUControl would produce it for A - B.
  assign Zero_Flag = ((a_val - b_val) == 32'd0);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    Opcode   = 6'b000000;
    a_val    = 32'h0000_0001;
    b_val    = 32'h0000_0002;

    // Outputs during reset equal FETCH outputs
    #2;
    check("rst_state",   32'(State),   0);
    check("rst_memread", 32'(MemRead), 1);
    check("rst_pcen",    32'(PC_En),   1);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("fetch_state",   32'(State),    0);
    check("fetch_irwrite", 32'(IRWrite),  1);
    check("fetch_srcb",    32'(ALUSrcB),  1);
    check("fetch_aluop",   32'(ALU_Op),   0);
    check("fetch_iord",    32'(IorD),     0);

    // lw: 0,1,2,3,4,0
    Opcode = 6'b100011;
    next_cycle();
    check("lw_decode",     32'(State),      1);
    check("lw_dec_srcb",   32'(ALUSrcB),    3);
    check("lw_dec_ill",    32'(Illegal_Op), 0);
    next_cycle();
    check("lw_memadr",     32'(State),   2);
    check("lw_adr_srcb",   32'(ALUSrcB), 2);
    check("lw_adr_srca",   32'(ALUSrcA), 1);
    next_cycle();
    check("lw_memrd",      32'(State),   3);
    check("lw_rd_iord",    32'(IorD),    1);
    check("lw_rd_memrd",   32'(MemRead), 1);
    check("lw_rd_irwr",    32'(IRWrite), 0);
    next_cycle();
    check("lw_memwb",      32'(State),    4);
    check("lw_wb_regwr",   32'(RegWrite), 1);
    check("lw_wb_m2r",     32'(MemtoReg), 1);
    check("lw_wb_regdst",  32'(RegDst),   0);
    next_cycle();
    check("lw_done",       32'(State), 0);

    // sw: 0,1,2,5,0
    Opcode = 6'b101011;
    next_cycle();
    next_cycle();
    check("sw_memadr",     32'(State), 2);
    next_cycle();
    check("sw_memwr",      32'(State),    5);
    check("sw_memwrite",   32'(MemWrite), 1);
    check("sw_memread",    32'(MemRead),  0);
    check("sw_iord",       32'(IorD),     1);
    next_cycle();
    check("sw_done",       32'(State), 0);

    // R-type add with A=12737398, B=12737399
    Opcode = 6'b000000;
    a_val  = 32'h12737398;
    b_val  = 32'h12737399;
    next_cycle();
    next_cycle();
    check("r_execute",     32'(State),   6);
    check("r_aluop",       32'(ALU_Op),  2);
    check("r_srca",        32'(ALUSrcA), 1);
    check("r_srcb",        32'(ALUSrcB), 0);
    next_cycle();
    check("r_aluwb",       32'(State),    7);
    check("r_regwr",       32'(RegWrite), 1);
    check("r_regdst",      32'(RegDst),   1);
    next_cycle();
    check("r_done",        32'(State), 0);

    // beq taken: A == B; Zero_Flag must be ignored in DECODE
    Opcode = 6'b000100;
    a_val  = 32'h12737398;
    b_val  = 32'h12737398;
    next_cycle();
    check("beq_dec_pcen",  32'(PC_En), 0);
    next_cycle();
    check("beq_branch",    32'(State),    8);
    check("beq_aluop",     32'(ALU_Op),   1);
    check("beq_pcsrc",     32'(PCSource), 1);
    check("beq_pcen_tk",   32'(PC_En),    1);
    next_cycle();
    check("beq_done",      32'(State), 0);

    // beq not taken: B = A + 1
    b_val = 32'h12737399;
    next_cycle();
    next_cycle();
    check("beqn_branch",   32'(State), 8);
    check("beqn_pcen",     32'(PC_En), 0);
    next_cycle();
    check("beqn_done",     32'(State), 0);

    // j: 0,1,9,0
    Opcode = 6'b000010;
    next_cycle();
    next_cycle();
    check("j_jump",        32'(State),    9);
    check("j_pcsrc",       32'(PCSource), 2);
    check("j_pcen",        32'(PC_En),    1);
    next_cycle();
    check("j_done",        32'(State), 0);

    // addi: 0,1,10,11,0
    Opcode = 6'b001000;
    next_cycle();
    next_cycle();
    check("addi_ex",       32'(State),   10);
    check("addi_srcb",     32'(ALUSrcB), 2);
    next_cycle();
    check("addi_wb",       32'(State),    11);
    check("addi_regwr",    32'(RegWrite), 1);
    check("addi_regdst",   32'(RegDst),   0);
    check("addi_m2r",      32'(MemtoReg), 0);
    next_cycle();
    check("addi_done",     32'(State), 0);

    // Illegal opcode: one-cycle pulse in DECODE, back to FETCH
    Opcode = 6'b111111;
    next_cycle();
    check("ill_decode",    32'(State),      1);
    check("ill_pulse",     32'(Illegal_Op), 1);
    check("ill_regwr",     32'(RegWrite),   0);
    check("ill_memwr",     32'(MemWrite),   0);
    next_cycle();
    check("ill_fetch",     32'(State),      0);
    check("ill_pulse_end", 32'(Illegal_Op), 0);
    check("ill_regwr2",    32'(RegWrite),   0);
    check("ill_memwr2",    32'(MemWrite),   0);

    // Reset asserted mid-cycle while in MEMRD
    Opcode = 6'b100011;
    next_cycle();
    next_cycle();
    next_cycle();
    check("mid_memrd",     32'(State), 3);
    #3;
    reset = 1'b1;
    #1;
    check("mid_rst_state", 32'(State),   0);
    check("mid_rst_iord",  32'(IorD),    0);
    #1;
    reset = 1'b0;
    #1;
    check("post_memread",  32'(MemRead), 1);
    check("post_irwrite",  32'(IRWrite), 1);
    check("post_srcb",     32'(ALUSrcB), 1);
    check("post_pcen",     32'(PC_En),   1);
    next_cycle();
    check("post_decode",   32'(State),   1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
